// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer (C = msg^exp mod N) driving a Montgomery multiplier
//   clk, rst                 : clock, synchronous active-high reset
//   start/msg/exp/modulus/r2 : request and operands, sampled only in IDLE
//   busy, done, result       : status, one-cycle completion pulse, held result
//   mmm_start/a/b/m          : launch pulse, operands and modulus to the multiplier
//   mmm_r, mmm_done          : multiplier product and its valid pulse
module modexp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mmm_start,
    output logic [WIDTH-1:0] mmm_a,
    output logic [WIDTH-1:0] mmm_b,
    output logic [WIDTH-1:0] mmm_m,
    input  logic [WIDTH-1:0] mmm_r,
    input  logic             mmm_done
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] IDLE = 3'd0, PRE_M = 3'd1, PRE_X = 3'd2, SQR = 3'd3,
                           MUL = 3'd4, POST = 3'd5, DONE = 3'd6;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic [2:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] exp_q, exp_d, m_q, m_d, r2_q, r2_d, mbar_q, mbar_d, x_q, x_d;
    logic [WIDTH-1:0] result_q, result_d, a_q, a_d, b_q, b_d;
    logic             start_q, launch;
    // Operands are chosen together with the next state so each op state is
    // entered with its operands already on mmm_a/mmm_b and mmm_start high.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        exp_d    = exp_q;
        m_d      = m_q;
        r2_d     = r2_q;
        mbar_d   = mbar_q;
        x_d      = x_q;
        result_d = result_q;
        a_d      = a_q;
        b_d      = b_q;
        launch   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                exp_d   = exp;
                m_d     = modulus;
                r2_d    = r2;
                k_d     = KW'(WIDTH - 1);
                a_d     = msg;
                b_d     = r2;
                state_d = PRE_M;
                launch  = 1'b1;
            end
            PRE_M: if (mmm_done) begin
                mbar_d  = mmm_r;
                a_d     = ONE;
                b_d     = r2_q;
                state_d = PRE_X;
                launch  = 1'b1;
            end
            PRE_X, SQR, MUL: if (mmm_done) begin
                x_d    = mmm_r;
                a_d    = mmm_r;
                b_d    = mmm_r;
                launch = 1'b1;
                // PRE_X always falls into the first square; SQR/MUL take the loop step
                if (state_q == SQR && exp_q[k_q]) begin
                    b_d     = mbar_q;
                    state_d = MUL;
                end else if (state_q != PRE_X && k_q == '0) begin
                    b_d     = ONE;
                    state_d = POST;
                end else begin
                    k_d     = (state_q == PRE_X) ? k_q : k_q - KW'(1);
                    state_d = SQR;
                end
            end
            POST: if (mmm_done) begin
                result_d = mmm_r;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            exp_q    <= '0;
            m_q      <= '0;
            r2_q     <= '0;
            mbar_q   <= '0;
            x_q      <= '0;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            exp_q    <= exp_d;
            m_q      <= m_d;
            r2_q     <= r2_d;
            mbar_q   <= mbar_d;
            x_q      <= x_d;
            result_q <= result_d;
            a_q      <= a_d;
            b_q      <= b_d;
            start_q  <= launch;
        end
    end
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = state_q == DONE;
    assign result    = result_q;
    assign mmm_start = start_q;
    assign mmm_a     = a_q;
    assign mmm_b     = b_q;
    assign mmm_m     = m_q;
endmodule
